// File: rtl/hamming_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_tx_encoder
//  Description : Accepts 11-bit payloads over a valid/ready handshake, encodes
//                each into a Hamming(15,11) codeword (with an optional single
//                bit flip for exercising the receive-side checker), presents
//                the word in parallel and then serializes it as a framed line:
//                start bit (0), 15 code bits LSB first, stop bit (1).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CLKS_PER_BIT  clock cycles each serial bit is held on tx_line (>= 1)
//  Ports
//    clk         in   1   system clock, rising edge
//    rst         in   1   synchronous active-high reset
//    data_in     in  11   payload to encode
//    in_valid    in   1   payload present
//    in_ready    out  1   block can accept (IDLE and not in reset)
//    inj_en      in   1   flip one codeword bit for this payload
//    inj_pos     in   4   codeword index to flip (0..14); 15 = no flip
//    codeword    out 15   registered encoded word (including injected flip)
//    cw_valid    out  1   one-cycle pulse the cycle after accept
//    tx_line     out  1   serial line, idles high
//    busy        out  1   high while a frame is in flight
//    frame_done  out  1   one-cycle pulse on the first IDLE cycle after a frame
// ============================================================================
module hamming_tx_encoder #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        inj_en,
  input  logic [3:0]  inj_pos,
  output logic [14:0] codeword,
  output logic        cw_valid,
  output logic        tx_line,
  output logic        busy,
  output logic        frame_done
);

  // Bit-period counter is at least one bit wide so CLKS_PER_BIT=1 still
  // produces a legal (always-zero) counter.
  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       BIT_LAST = 4'd14;

  // Parity coverage masks over the 15-bit word (index 0 = LSB). Each parity
  // bit sits at Hamming position 2^k, i.e. index 0, 1, 3 and 7.
  localparam logic [14:0] P0_MASK = 15'h5554;  // cw[2,4,6,8,10,12,14]
  localparam logic [14:0] P1_MASK = 15'h6664;  // cw[2,5,6,9,10,13,14]
  localparam logic [14:0] P3_MASK = 15'h7870;  // cw[4,5,6,11,12,13,14]
  localparam logic [14:0] P7_MASK = 15'h7F00;  // cw[8..14]

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_next;
  logic [3:0]       bit_idx;
  logic [3:0]       bit_idx_next;

  logic             accept;
  logic             bit_end;

  logic [14:0]      data_placed;
  logic             p0;
  logic             p1;
  logic             p3;
  logic             p7;
  logic [14:0]      enc_word;
  logic [14:0]      flip_mask;
  logic [14:0]      enc_final;

  logic             tx_next;
  logic             busy_next;
  logic             done_next;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // Gating with rst makes a reset cycle refuse a simultaneous in_valid.
  assign in_ready = (state == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign bit_end  = (clk_cnt == CNT_LAST);

  // --------------------------------------------------------------------------
  // Encoder: place data bits in their non-power-of-two slots, derive parity
  // from the placed word, then apply the optional single-bit flip.
  // --------------------------------------------------------------------------
  always_comb begin
    data_placed = {data_in[6:0], 1'b0, data_in[9:7], 1'b0, data_in[10], 2'b00};
    p0          = ^(data_placed & P0_MASK);
    p1          = ^(data_placed & P1_MASK);
    p3          = ^(data_placed & P3_MASK);
    p7          = ^(data_placed & P7_MASK);
    enc_word    = data_placed | {7'b0, p7, 3'b0, p3, 1'b0, p1, p0};

    // inj_pos = 15 addresses no bit, so it never flips anything.
    flip_mask = '0;
    if (inj_en && (inj_pos != 4'hF)) begin
      flip_mask = 15'd1 << inj_pos;
    end
    enc_final = enc_word ^ flip_mask;
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_idx <= bit_idx_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next   = S_START;
          clk_cnt_next = '0;
          bit_idx_next = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next   = S_DATA;
          clk_cnt_next = '0;
          bit_idx_next = '0;
        end else begin
          clk_cnt_next = clk_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx == BIT_LAST) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx + 4'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_next   = S_IDLE;
          clk_cnt_next = '0;
          bit_idx_next = '0;
        end else begin
          clk_cnt_next = clk_cnt + CNT_ONE;
        end
      end
      default: begin
        state_next   = S_IDLE;
        clk_cnt_next = '0;
        bit_idx_next = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output logic
  // --------------------------------------------------------------------------
  // Outputs are decoded from the *next* state and registered below, so the
  // registered tx_line/busy line up with the state register cycle for cycle
  // and tx_line can only move when the state or bit index moves.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = codeword[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE);
    done_next = (state == S_STOP) && (state_next == S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Output and datapath registers
  // --------------------------------------------------------------------------
  // codeword is loaded on the accept edge; DATA is at least one START bit
  // period later, so the serializer always reads the freshly loaded word.
  always_ff @(posedge clk) begin
    if (rst) begin
      codeword   <= '0;
      cw_valid   <= 1'b0;
      tx_line    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cw_valid   <= accept;
      tx_line    <= tx_next;
      busy       <= busy_next;
      frame_done <= done_next;
      if (accept) begin
        codeword <= enc_final;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_tx_encoder
//  Description : Directed self-checking bench for hamming_tx_encoder. One
//                instance runs at 4 clocks per bit for the framed-line tests,
//                a second at 1 clock per bit for the full payload round trip
//                through a syndrome-decoding receiver model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hamming_tx_encoder;

  localparam int C4 = 4;

  logic        clk = 1'b0;
  logic        rst;

  logic [10:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic        inj_en;
  logic [3:0]  inj_pos;
  logic [14:0] codeword;
  logic        cw_valid;
  logic        tx_line;
  logic        busy;
  logic        frame_done;

  logic [10:0] data_in_1;
  logic        in_valid_1;
  logic        in_ready_1;
  logic [14:0] codeword_1;
  logic        cw_valid_1;
  logic        tx_line_1;
  logic        busy_1;
  logic        frame_done_1;

  int tests = 0;
  int fails = 0;

  hamming_tx_encoder #(.CLKS_PER_BIT(C4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .inj_en(inj_en), .inj_pos(inj_pos), .codeword(codeword), .cw_valid(cw_valid),
    .tx_line(tx_line), .busy(busy), .frame_done(frame_done)
  );

  hamming_tx_encoder #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .inj_en(1'b0), .inj_pos(4'hF), .codeword(codeword_1), .cw_valid(cw_valid_1),
    .tx_line(tx_line_1), .busy(busy_1), .frame_done(frame_done_1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line image of a frame: start 0, code bits LSB first, stop 1.
  function automatic logic [16:0] frame_of(input logic [14:0] cw);
    return {1'b1, cw, 1'b0};
  endfunction

  // Receiver-side syndrome: XOR of Hamming positions (index+1) of set bits.
  function automatic logic [3:0] syndrome_of(input logic [14:0] cw);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < 15; i++) if (cw[i]) s = s ^ 4'(i + 1);
    return s;
  endfunction

  // Drives one accept on the C=4 instance from IDLE and records the frame.
  // Returns at the first IDLE cycle after the frame.
  task automatic run_frame(input logic [10:0] d, input logic ie, input logic [3:0] ip,
                           output logic [14:0] cw_obs, output logic [16:0] fr,
                           output int glitches, output int flag_errs,
                           output logic cwv0, output logic cwv1,
                           output logic done_end, output logic busy_end);
    data_in = d; inj_en = ie; inj_pos = ip; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; inj_en = 1'b0; inj_pos = 4'hF;
    cw_obs = codeword; cwv0 = cw_valid; cwv1 = 1'b1;
    glitches = 0; flag_errs = 0; fr = '0;
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k < C4; k++) begin
        if (k == 0) fr[b] = tx_line;
        else if (tx_line !== fr[b]) glitches++;
        if (busy !== 1'b1 || frame_done !== 1'b0 || in_ready !== 1'b0) flag_errs++;
        if (b == 0 && k == 1) cwv1 = cw_valid;
        tick();
      end
    end
    done_end = frame_done; busy_end = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; data_in = 11'h7FF; inj_en = 1'b0; inj_pos = 4'hF;
    in_valid_1 = 1'b0; data_in_1 = '0;
    tick(); tick();
    tests++; if (codeword !== 15'h0000) begin fails++; $display("FAIL reset_codeword got=%h exp=0000", codeword); end
    tests++; if (cw_valid !== 1'b0) begin fails++; $display("FAIL reset_cw_valid got=%b exp=0", cw_valid); end
    tests++; if (tx_line !== 1'b1) begin fails++; $display("FAIL reset_tx_line got=%b exp=1", tx_line); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic_frame();
    logic [14:0] cw; logic [16:0] fr; int gl, fe; logic c0, c1, de, be;
    run_frame(11'h001, 1'b0, 4'd0, cw, fr, gl, fe, c0, c1, de, be);
    tests++; if (cw !== 15'h0181) begin fails++; $display("FAIL basic_codeword got=%h exp=0181", cw); end
    tests++; if (c0 !== 1'b1 || c1 !== 1'b0) begin fails++; $display("FAIL basic_cw_valid_pulse got=%b%b exp=10", c0, c1); end
    tests++; if (fr !== frame_of(15'h0181)) begin fails++; $display("FAIL basic_line got=%h exp=%h", fr, frame_of(15'h0181)); end
    tests++; if (gl !== 0) begin fails++; $display("FAIL basic_bit_hold got=%0d exp=0 glitches", gl); end
    tests++; if (fe !== 0) begin fails++; $display("FAIL basic_busy_flags got=%0d exp=0 bad cycles", fe); end
    tests++; if (de !== 1'b1 || be !== 1'b0) begin fails++; $display("FAIL basic_frame_end got done=%b busy=%b exp done=1 busy=0", de, be); end
    tick();
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse_width got=%b exp=0", frame_done); end
    tests++; if (codeword !== 15'h0181) begin fails++; $display("FAIL basic_codeword_hold got=%h exp=0181", codeword); end
  endtask

  task automatic test_vectors();
    logic [10:0] din [3] = '{11'h400, 11'h7FF, 11'h000};
    logic [14:0] exp [3] = '{15'h0007, 15'h7FFF, 15'h0000};
    logic [14:0] cw; logic [16:0] fr; int gl, fe; logic c0, c1, de, be;
    for (int i = 0; i < 3; i++) begin
      run_frame(din[i], 1'b0, 4'd0, cw, fr, gl, fe, c0, c1, de, be);
      tests++; if (cw !== exp[i]) begin fails++; $display("FAIL vec_codeword d=%h got=%h exp=%h", din[i], cw, exp[i]); end
      tests++; if (fr !== frame_of(exp[i])) begin fails++; $display("FAIL vec_line d=%h got=%h exp=%h", din[i], fr, frame_of(exp[i])); end
    end
  endtask

  task automatic test_injection();
    logic [14:0] cw; logic [16:0] fr; int gl, fe; logic c0, c1, de, be;
    run_frame(11'h001, 1'b1, 4'd5, cw, fr, gl, fe, c0, c1, de, be);
    tests++; if (cw !== 15'h01A1) begin fails++; $display("FAIL inj5_codeword got=%h exp=01A1", cw); end
    tests++; if (syndrome_of(fr[15:1]) !== 4'd6) begin fails++; $display("FAIL inj5_rx_syndrome got=%0d exp=6", syndrome_of(fr[15:1])); end
    run_frame(11'h001, 1'b1, 4'd15, cw, fr, gl, fe, c0, c1, de, be);
    tests++; if (cw !== 15'h0181) begin fails++; $display("FAIL inj15_codeword got=%h exp=0181", cw); end
    tests++; if (syndrome_of(fr[15:1]) !== 4'd0) begin fails++; $display("FAIL inj15_rx_syndrome got=%0d exp=0", syndrome_of(fr[15:1])); end
    run_frame(11'h001, 1'b0, 4'd5, cw, fr, gl, fe, c0, c1, de, be);
    tests++; if (cw !== 15'h0181) begin fails++; $display("FAIL injoff_codeword got=%h exp=0181", cw); end
    run_frame(11'h000, 1'b1, 4'd14, cw, fr, gl, fe, c0, c1, de, be);
    tests++; if (cw !== 15'h4000) begin fails++; $display("FAIL inj14_codeword got=%h exp=4000", cw); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0; int nacc = 0; int rdy_busy = 0;
    int acc_cyc [2] = '{0, 0};
    logic done_at_b = 1'b0;
    data_in = 11'h001; in_valid = 1'b1;
    while (nacc < 2 && cyc < 300) begin
      if (busy && in_ready) rdy_busy++;
      if (in_valid && in_ready) begin
        acc_cyc[nacc] = cyc;
        if (nacc == 1) done_at_b = frame_done;
        nacc++;
      end
      tick();
      cyc++;
      if (nacc == 1) data_in = 11'h400;
      if (nacc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tests++; if (nacc !== 2) begin fails++; $display("FAIL b2b_accepts got=%0d exp=2 within 300 cycles", nacc); end
    tests++; if (acc_cyc[1] - acc_cyc[0] !== 69) begin fails++; $display("FAIL b2b_spacing got=%0d exp=69", acc_cyc[1] - acc_cyc[0]); end
    tests++; if (done_at_b !== 1'b1) begin fails++; $display("FAIL b2b_accept_in_done_cycle got=%b exp=1", done_at_b); end
    tests++; if (rdy_busy !== 0) begin fails++; $display("FAIL b2b_ready_while_busy got=%0d exp=0 cycles", rdy_busy); end
    tests++; if (codeword !== 15'h0007 || cw_valid !== 1'b1) begin fails++; $display("FAIL b2b_second_word got=%h/%b exp=0007/1", codeword, cw_valid); end
    for (int i = 0; i < 17 * C4; i++) tick();
    tests++; if (frame_done !== 1'b1) begin fails++; $display("FAIL b2b_second_done got=%b exp=1", frame_done); end
  endtask

  task automatic test_reset_mid_frame();
    logic [14:0] cw; logic [16:0] fr; int gl, fe; logic c0, c1, de, be;
    tick();
    data_in = 11'h400; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Start is cycles 0..3, so DATA bit 7 occupies cycles 32..35.
    for (int i = 0; i < 33; i++) tick();
    tests++; if (tx_line !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL midrst_bit7_line got=%b busy=%b exp=0/1", tx_line, busy); end
    rst = 1'b1;
    tick();
    tests++; if (tx_line !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs got tx=%b busy=%b done=%b exp 1/0/0", tx_line, busy, frame_done); end
    tests++; if (codeword !== 15'h0000 || cw_valid !== 1'b0) begin fails++; $display("FAIL midrst_codeword got=%h/%b exp=0000/0", codeword, cw_valid); end
    rst = 1'b0;
    #1;
    run_frame(11'h7FF, 1'b0, 4'd0, cw, fr, gl, fe, c0, c1, de, be);
    tests++; if (cw !== 15'h7FFF || fr !== frame_of(15'h7FFF)) begin fails++; $display("FAIL midrst_clean_frame got cw=%h line=%h exp 7FFF/%h", cw, fr, frame_of(15'h7FFF)); end
    tests++; if (fe !== 0 || gl !== 0 || de !== 1'b1) begin fails++; $display("FAIL midrst_clean_flags got bad=%0d gl=%0d done=%b exp 0/0/1", fe, gl, de); end
  endtask

  task automatic test_roundtrip();
    int bad = 0; int first_bad = -1;
    logic [16:0] fr; logic [14:0] cw; logic [10:0] dout; logic done;
    for (int p = 0; p < 2048; p++) begin
      data_in_1 = 11'(p); in_valid_1 = 1'b1;
      tick();
      in_valid_1 = 1'b0;
      for (int k = 0; k < 17; k++) begin fr[k] = tx_line_1; tick(); end
      done = frame_done_1;
      cw = fr[15:1];
      dout = {cw[2], cw[6], cw[5], cw[4], cw[14:8]};
      if (fr[0] !== 1'b0 || fr[16] !== 1'b1 || syndrome_of(cw) !== 4'd0 || dout !== 11'(p) || done !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = p;
      end
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL roundtrip_c1 got=%0d bad payloads (first=%0d) exp=0", bad, first_bad); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_vectors();
    test_injection();
    test_back_to_back();
    test_reset_mid_frame();
    test_roundtrip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
